// File: rtl/serializador_param.sv
// serializador_param: parametrised parallel-to-serial converter.
// Takes WIDTH-bit words over a valid/ready handshake and emits one bit per
// enabled clock. Idle slots and the post-reset training period carry the
// COMMA word so the downstream deserializer can find word alignment.
module serializador_param #(
  parameter int unsigned       WIDTH      = 8,
  parameter logic [WIDTH-1:0]  COMMA      = WIDTH'(8'hBC),
  parameter int unsigned       SYNC_WORDS = 4,
  parameter bit                LSB_FIRST  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enb,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             out,
  output logic             frame_start,
  output logic             is_comma,
  output logic             sync_done
);

  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam int unsigned SYNC_W = $clog2(SYNC_WORDS + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_WORDS - 1);

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  sh;        // word currently being transmitted
  logic [WIDTH-1:0]  sh_ord;    // same word, reordered so bit cnt is sent at slot cnt
  logic [CNT_W-1:0]  cnt;       // bit slot within the current word
  logic [SYNC_W-1:0] sync_cnt;  // training words completed
  logic              filler;    // current word is COMMA filler
  logic              at_last;
  logic              transfer;

  // Present the shift register in transmission order.
  for (genvar g = 0; g < WIDTH; g++) begin : g_ord
    if (LSB_FIRST) begin : g_lsb
      assign sh_ord[g] = sh[g];
    end else begin : g_msb
      assign sh_ord[g] = sh[WIDTH-1-g];
    end
  end

  // Handshake: a new word is taken only at a word boundary once trained.
  assign at_last   = (cnt == CNT_LAST);
  assign ready_out = enb & at_last & (state == ST_RUN);
  assign transfer  = valid_in & ready_out;

  // Bit emission, word loading and training sequencer.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      out         <= 1'b0;
      frame_start <= 1'b0;
      is_comma    <= 1'b0;
      sync_done   <= 1'b0;
      sh          <= COMMA;
      filler      <= 1'b1;
      cnt         <= '0;
      sync_cnt    <= '0;
      state       <= ST_SYNC;
    end else if (enb) begin
      out         <= sh_ord[cnt];
      frame_start <= (cnt == '0);
      is_comma    <= filler;
      if (at_last) begin
        cnt <= '0;
        // The next word is loaded on the same edge that emits the last bit.
        if (transfer) begin
          sh     <= data_in;
          filler <= 1'b0;
        end else begin
          sh     <= COMMA;
          filler <= 1'b1;
        end
        if (state == ST_SYNC) begin
          sync_cnt <= sync_cnt + SYNC_W'(1);
          if (sync_cnt == SYNC_LAST) begin
            state     <= ST_RUN;
            sync_done <= 1'b1;
          end
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serializador_param.sv
// Bench for serializador_param: directed steps plus random traffic, checked
// against a word-level model of the serial stream (word list indexed by
// enabled-cycle count).
module tb_serializador_param;

  localparam int SYNCW = 4;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0, enb_a = 1'b0, valid_a = 1'b0;
  logic [7:0] data_a = '0;
  logic       ready_a, out_a, fs_a, isc_a, sd_a;
  logic       rst_b = 1'b0, enb_b = 1'b0, valid_b = 1'b0;
  logic [9:0] data_b = '0;
  logic       ready_b, out_b, fs_b, isc_b, sd_b;

  serializador_param dut_a (
    .clk(clk), .reset_L(rst_a), .enb(enb_a), .data_in(data_a), .valid_in(valid_a),
    .ready_out(ready_a), .out(out_a), .frame_start(fs_a), .is_comma(isc_a), .sync_done(sd_a)
  );

  serializador_param #(.WIDTH(10), .COMMA(10'h17C), .SYNC_WORDS(4), .LSB_FIRST(1'b1)) dut_b (
    .clk(clk), .reset_L(rst_b), .enb(enb_b), .data_in(data_b), .valid_in(valid_b),
    .ready_out(ready_b), .out(out_b), .frame_start(fs_b), .is_comma(isc_b), .sync_done(sd_b)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Selected instance and its parameters
  bit          sel = 1'b0;
  int          W = 8;
  logic [15:0] CM = 16'h00BC;
  bit          LSBF = 1'b0;

  // Model: e = enabled edges since reset; mword[k] = k-th word on the line
  int          e;
  logic [15:0] mword [0:1023];
  bit          mfill [0:1023];
  bit          last_xfer, seen_rdy;

  logic o_rdy, o_out, o_fs, o_isc, o_sd;
  always_comb begin
    if (sel) begin
      o_rdy = ready_b; o_out = out_b; o_fs = fs_b; o_isc = isc_b; o_sd = sd_b;
    end else begin
      o_rdy = ready_a; o_out = out_a; o_fs = fs_a; o_isc = isc_a; o_sd = sd_a;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic select_inst(input bit s);
    sel = s;
    if (!s) begin W = 8;  CM = 16'h00BC; LSBF = 1'b0; end
    else    begin W = 10; CM = 16'h017C; LSBF = 1'b1; end
  endtask

  task automatic model_reset();
    e = 0;
    for (int i = 0; i < 1024; i++) begin
      mword[i] = CM;
      mfill[i] = 1'b1;
    end
  endtask

  task automatic drive(input bit en, input bit vld, input logic [15:0] d);
    if (!sel) begin enb_a = en; valid_a = vld; data_a = d[7:0]; end
    else      begin enb_b = en; valid_b = vld; data_b = d[9:0]; end
  endtask

  task automatic set_rst(input bit v);
    if (!sel) rst_a = v; else rst_b = v;
  endtask

  // One clock: check ready before the edge, update model, check outputs after.
  task automatic cyc(input bit en, input bit vld, input logic [15:0] d);
    bit          rdy_exp;
    int          w, p, bi;
    logic [15:0] tmp;
    bit          eo, ef, ec, es;
    drive(en, vld, d);
    #1;
    rdy_exp = en && (e % W == W - 1) && (e / W >= SYNCW);
    seen_rdy = o_rdy;
    chk("ready_out", 32'(o_rdy), 32'(rdy_exp));
    last_xfer = vld && rdy_exp;
    if (last_xfer) begin
      mword[e / W + 1] = d;
      mfill[e / W + 1] = 1'b0;
    end
    @(posedge clk);
    #1;
    if (en) e = e + 1;
    if (e == 0) begin
      eo = 1'b0; ef = 1'b0; ec = 1'b0;
    end else begin
      w   = (e - 1) / W;
      p   = (e - 1) % W;
      bi  = LSBF ? p : (W - 1 - p);
      tmp = mword[w] >> bi;
      eo  = tmp[0];
      ef  = (p == 0);
      ec  = mfill[w];
    end
    es = (e >= SYNCW * W);
    chk("out", 32'(o_out), 32'(eo));
    chk("frame_start", 32'(o_fs), 32'(ef));
    chk("is_comma", 32'(o_isc), 32'(ec));
    chk("sync_done", 32'(o_sd), 32'(es));
  endtask

  task automatic reset_inst();
    set_rst(1'b0);
    drive(1'b1, 1'b1, 16'hFFFF);
    @(posedge clk);
    #1;
    chk("rst_out", 32'(o_out), 32'd0);
    chk("rst_frame_start", 32'(o_fs), 32'd0);
    chk("rst_is_comma", 32'(o_isc), 32'd0);
    chk("rst_sync_done", 32'(o_sd), 32'd0);
    chk("rst_ready", 32'(o_rdy), 32'd0);
    set_rst(1'b1);
    model_reset();
  endtask

  // Enabled cycles with valid low until ready_out is seen (bounded).
  task automatic count_to_ready(output int n);
    n = 0;
    cyc(1'b1, 1'b0, 16'h0);
    while (!seen_rdy && n < 200) begin
      n = n + 1;
      cyc(1'b1, 1'b0, 16'h0);
    end
  endtask

  // Hold valid/data until the handshake; n = cycles taken (bounded).
  task automatic send(input logic [15:0] d, output int n);
    n = 0;
    do begin
      cyc(1'b1, 1'b1, d);
      n = n + 1;
    end while (!last_xfer && n < 4 * W);
    chk("handshake", 32'(last_xfer), 32'd1);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b1, 1'b0, 16'h0);
  endtask

  task automatic random_run(input int k);
    bit          hold;
    bit          en, vld;
    logic [15:0] d, mask;
    hold = 1'b0;
    vld  = 1'b0;
    d    = '0;
    mask = 16'((1 << W) - 1);
    for (int i = 0; i < k; i++) begin
      en = ($urandom_range(0, 7) != 0);
      if (!hold) begin
        vld = ($urandom_range(0, 1) == 1);
        d   = 16'($urandom) & mask;
      end
      cyc(en, vld, d);
      hold = vld && !last_xfer;
    end
  endtask

  initial begin
    int n;
    select_inst(1'b0);
    model_reset();

    // Training: COMMA words, ready after 4 words + 1 filler word
    reset_inst();
    count_to_ready(n);
    chk("sync_len_w8", 32'(n), 32'(SYNCW * W + W - 1));

    // Single data word then filler
    send(16'h00A5, n);
    idle(2 * W);

    // Back-to-back words form a gapless stream
    send(16'h0000, n);
    send(16'h00FF, n);
    chk("b2b_gap1", 32'(n), 32'(W));
    send(16'h003C, n);
    chk("b2b_gap2", 32'(n), 32'(W));
    idle(2 * W);

    // enb low for 5 cycles mid-word
    send(16'h005A, n);
    idle(3);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 16'h0);
    idle(2 * W);

    // Reset in the middle of a data word
    send(16'h00F8, n);
    idle(5);
    set_rst(1'b0);
    #1;
    chk("midrst_out", 32'(o_out), 32'd0);
    chk("midrst_sync_done", 32'(o_sd), 32'd0);
    chk("midrst_frame_start", 32'(o_fs), 32'd0);
    @(posedge clk);
    #1;
    set_rst(1'b1);
    model_reset();
    count_to_ready(n);
    chk("sync_len_after_rst", 32'(n), 32'(SYNCW * W + W - 1));

    random_run(300);
    drive(1'b0, 1'b0, 16'h0);

    // Second configuration: WIDTH=10, LSB first
    select_inst(1'b1);
    reset_inst();
    count_to_ready(n);
    chk("sync_len_w10", 32'(n), 32'(SYNCW * W + W - 1));
    send(16'h0283, n);
    send(16'h0155, n);
    chk("b2b_gap_w10", 32'(n), 32'(W));
    idle(2 * W);
    random_run(250);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
